fwd_scoreboard: RTL and testbench

- Parametrised successor to the combinational rs1/rs2 forwarding unit.
- Keeps its own shadow pipeline of in-flight destination tags for DEPTH stages past ID, with per-entry result latency.
- Produces per-source forward selects and a load-use/multi-cycle stall for the instruction in ID.
- Sits beside the ID stage. The datapath uses the selects to mux operands into ID/EX, and uses stall to hold PC and IF/ID.

---
 rtl/fwd_scoreboard_if.sv | 30 +++
 rtl/fwd_scoreboard.sv | 92 +++++++++
 tb/tb_fwd_scoreboard.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// ID-stage bus for the forwarding scoreboard. The instruction fields go in,
// and the forward selects, the stall and the stall counter come out.
interface fwd_scoreboard_if #(
  parameter int NSRC = 2,
  parameter int RAW  = 5,
  parameter int LATW = 2,
  parameter int SELW = 2,
  parameter int CNTW = 16
);
  logic                 id_valid;
  logic [NSRC*RAW-1:0]  id_rs;
  logic [NSRC-1:0]      id_rs_used;
  logic [RAW-1:0]       id_rd;
  logic                 id_we;
  logic [LATW-1:0]      id_lat;
  logic                 flush;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 stall;
  logic [CNTW-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_we, id_lat, flush,
    input  fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_we, id_lat, flush,
    output fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Shadow pipeline of in-flight destination tags. It computes the per-source
// forward selects and the load-use/multi-cycle stall for the instruction in ID.
module fwd_scoreboard #(
  parameter int NSRC  = 2,
  parameter int DEPTH = 3,
  parameter int RAW   = 5,
  parameter int LATW  = 2,
  parameter int SELW  = $clog2(DEPTH+1),
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fwd_scoreboard_if.slave  sb
);

  typedef struct packed {
    logic            valid;
    logic [RAW-1:0]  rd;
    logic            we;
    logic [LATW-1:0] lat;
  } entry_t;

  entry_t [DEPTH-1:0]   pipe_q, pipe_d;
  logic   [CNTW-1:0]    cnt_q, cnt_d;
  logic   [NSRC-1:0]    not_ready;
  logic   [NSRC*SELW-1:0] sel;
  logic                 stall;

  // Entry 0 is the youngest producer, so the first hit while scanning upward
  // wins. A result exists only once the entry index reaches its latency.
  always_comb begin : match_logic
    logic           found;
    logic [RAW-1:0] rs;
    sel       = '0;
    not_ready = '0;
    found     = 1'b0;
    rs        = '0;
    for (int i = 0; i < NSRC; i++) begin
      rs    = sb.id_rs[i*RAW +: RAW];
      found = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && sb.id_rs_used[i] && pipe_q[k].valid && pipe_q[k].we &&
            (pipe_q[k].rd != '0) && (pipe_q[k].rd == rs)) begin
          found = 1'b1;
          if (k >= int'(pipe_q[k].lat)) begin
            sel[i*SELW +: SELW] = SELW'(k + 1);
          end else begin
            not_ready[i] = 1'b1;
          end
        end
      end
    end
  end

  assign stall = sb.id_valid && !sb.flush && (|not_ready);

  always_comb begin
    pipe_d = '0;
    for (int k = 1; k < DEPTH; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
    if (sb.id_valid && !stall && !sb.flush) begin
      pipe_d[0].valid = 1'b1;
      pipe_d[0].rd    = sb.id_rd;
      pipe_d[0].we    = sb.id_we;
      pipe_d[0].lat   = sb.id_lat;
    end
    cnt_d = (stall && (cnt_q != '1)) ? cnt_q + CNTW'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
      cnt_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sb.fwd_sel   = sel;
  assign sb.stall     = stall;
  assign sb.stall_cnt = cnt_q;

  // A latency past the last tracked stage could never be forwarded.
  property legal_lat_p;
    @(posedge clk) disable iff (!rst_n)
      (sb.id_valid && !sb.flush) |-> (int'(sb.id_lat) < DEPTH);
  endproperty
  legal_lat_a: assert property (legal_lat_p);

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard. It compares the DUT against a model that keeps
// a list of issued producers keyed by issue cycle. A second instance with a
// 4-bit counter shares the same inputs so that saturation can be observed.
module tb_fwd_scoreboard;
  localparam int NSRC   = 2;
  localparam int DEPTH  = 3;
  localparam int RAW    = 5;
  localparam int LATW   = 2;
  localparam int SELW   = $clog2(DEPTH+1);
  localparam int CNTW   = 16;
  localparam int CNTW_S = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.NSRC(NSRC), .RAW(RAW), .LATW(LATW), .SELW(SELW), .CNTW(CNTW))   ifMain();
  fwd_scoreboard_if #(.NSRC(NSRC), .RAW(RAW), .LATW(LATW), .SELW(SELW), .CNTW(CNTW_S)) ifSmall();

  assign ifSmall.id_valid   = ifMain.id_valid;
  assign ifSmall.id_rs      = ifMain.id_rs;
  assign ifSmall.id_rs_used = ifMain.id_rs_used;
  assign ifSmall.id_rd      = ifMain.id_rd;
  assign ifSmall.id_we      = ifMain.id_we;
  assign ifSmall.id_lat     = ifMain.id_lat;
  assign ifSmall.flush      = ifMain.flush;

  fwd_scoreboard #(.NSRC(NSRC), .DEPTH(DEPTH), .RAW(RAW), .LATW(LATW), .SELW(SELW), .CNTW(CNTW))
    dutMain (.clk(clk), .rst_n(rst_n), .sb(ifMain.slave));
  fwd_scoreboard #(.NSRC(NSRC), .DEPTH(DEPTH), .RAW(RAW), .LATW(LATW), .SELW(SELW), .CNTW(CNTW_S))
    dutSmall (.clk(clk), .rst_n(rst_n), .sb(ifSmall.slave));

  typedef struct {
    logic [RAW-1:0] rd;
    logic           we;
    int             lat;
    int             issue;
  } prod_t;

  prod_t prods[$];
  int cycle;
  int stallTotal;
  int checks;
  int errors;

  logic [NSRC*SELW-1:0] obsSel;
  logic                 obsStall;
  logic [CNTW-1:0]      obsCnt;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // A producer accepted at cycle c sits in entry (now - c - 1). Its result is
  // usable once that age reaches its latency.
  function automatic void modelEval(input logic [NSRC*RAW-1:0] rs, input logic [NSRC-1:0] used,
                                    output logic [NSRC*SELW-1:0] eSel, output logic notReady);
    int bestAge;
    int bestLat;
    int age;
    logic [RAW-1:0] src;
    eSel = '0;
    notReady = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      bestAge = -1;
      bestLat = 0;
      src = rs[i*RAW +: RAW];
      foreach (prods[p]) begin
        age = cycle - prods[p].issue - 1;
        if (used[i] && prods[p].we && (prods[p].rd != 0) && (prods[p].rd == src) &&
            (age < DEPTH) && ((bestAge < 0) || (age < bestAge))) begin
          bestAge = age;
          bestLat = prods[p].lat;
        end
      end
      if (bestAge >= 0) begin
        if (bestAge >= bestLat) eSel[i*SELW +: SELW] = SELW'(bestAge + 1);
        else notReady = 1'b1;
      end
    end
  endfunction

  function automatic int satTo(input int v, input int w);
    int maxV;
    maxV = (1 << w) - 1;
    return (v > maxV) ? maxV : v;
  endfunction

  task automatic applyStimulus(input logic v, input logic [NSRC*RAW-1:0] rs, input logic [NSRC-1:0] used,
                               input logic [RAW-1:0] rd, input logic we, input logic [LATW-1:0] lat,
                               input logic fl);
    logic [NSRC*SELW-1:0] eSel;
    logic eNotReady;
    logic eStall;
    prod_t np;
    ifMain.id_valid   = v;
    ifMain.id_rs      = rs;
    ifMain.id_rs_used = used;
    ifMain.id_rd      = rd;
    ifMain.id_we      = we;
    ifMain.id_lat     = lat;
    ifMain.flush      = fl;
    @(negedge clk);
    modelEval(rs, used, eSel, eNotReady);
    eStall = v && !fl && eNotReady;
    obsSel   = ifMain.fwd_sel;
    obsStall = ifMain.stall;
    obsCnt   = ifMain.stall_cnt;
    checkOutput("fwd_sel", 32'(ifMain.fwd_sel), 32'(eSel));
    checkOutput("stall", 32'(ifMain.stall), 32'(eStall));
    checkOutput("stall_cnt", 32'(ifMain.stall_cnt), 32'(satTo(stallTotal, CNTW)));
    checkOutput("small_fwd_sel", 32'(ifSmall.fwd_sel), 32'(eSel));
    checkOutput("small_stall_cnt", 32'(ifSmall.stall_cnt), 32'(satTo(stallTotal, CNTW_S)));
    @(posedge clk);
    if (v && !fl && !eStall) begin
      np.rd = rd;
      np.we = we;
      np.lat = int'(lat);
      np.issue = cycle;
      prods.push_back(np);
    end
    if (eStall) stallTotal++;
    cycle++;
    while ((prods.size() > 0) && (cycle - prods[0].issue - 1 >= DEPTH)) void'(prods.pop_front());
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_sel"}, 32'(ifMain.fwd_sel), 32'd0);
    checkOutput({tag, "_stall"}, 32'(ifMain.stall), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(ifMain.stall_cnt), 32'd0);
    checkOutput({tag, "_small_cnt"}, 32'(ifSmall.stall_cnt), 32'd0);
  endtask

  task automatic releaseReset();
    ifMain.id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prods.delete();
    stallTotal = 0;
    @(posedge clk);
    cycle++;
    #1;
  endtask

  initial begin
    logic [NSRC*RAW-1:0] r;
    checks = 0;
    errors = 0;
    cycle = 0;
    stallTotal = 0;

    rst_n = 1'b0;
    ifMain.id_valid   = 1'b1;
    ifMain.id_rs      = NSRC*RAW'($urandom);
    ifMain.id_rs_used = '1;
    ifMain.id_rd      = RAW'($urandom);
    ifMain.id_we      = 1'b1;
    ifMain.id_lat     = LATW'($urandom_range(0, DEPTH-1));
    ifMain.flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    releaseReset();

    applyStimulus(1'b1, {5'd2, 5'd1}, 2'b11, 5'd0, 1'b0, 2'd0, 1'b0);
    checkOutput("empty_sel", 32'(obsSel), 32'd0);

    // Back-to-back ALU result walking down the shadow pipeline.
    applyStimulus(1'b1, '0, 2'b00, 5'd5, 1'b1, 2'd0, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      applyStimulus(1'b1, {5'd0, 5'd5}, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
      checkOutput("alu_sel", 32'(obsSel[SELW-1:0]), (j < 4) ? 32'(j) : 32'd0);
      checkOutput("alu_stall", 32'(obsStall), 32'd0);
    end

    // Load-use: one bubble, then forward from entry 1.
    applyStimulus(1'b1, '0, 2'b00, 5'd7, 1'b1, 2'd1, 1'b0);
    applyStimulus(1'b1, {5'd7, 5'd0}, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0);
    checkOutput("ld_stall", 32'(obsStall), 32'd1);
    applyStimulus(1'b1, {5'd7, 5'd0}, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0);
    checkOutput("ld_stall_after", 32'(obsStall), 32'd0);
    checkOutput("ld_sel", 32'(obsSel[2*SELW-1:SELW]), 32'd2);
    checkOutput("ld_cnt", 32'(obsCnt), 32'd1);

    // Youngest producer wins; rd=0 and we=0 never match.
    applyStimulus(1'b1, '0, 2'b00, 5'd3, 1'b1, 2'd0, 1'b0);
    applyStimulus(1'b1, '0, 2'b00, 5'd3, 1'b1, 2'd0, 1'b0);
    applyStimulus(1'b1, {5'd0, 5'd3}, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
    checkOutput("young_sel", 32'(obsSel[SELW-1:0]), 32'd1);
    applyStimulus(1'b1, '0, 2'b00, 5'd0, 1'b1, 2'd0, 1'b0);
    applyStimulus(1'b1, {5'd0, 5'd0}, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
    checkOutput("rd0_sel", 32'(obsSel), 32'd0);
    applyStimulus(1'b1, '0, 2'b00, 5'd9, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, {5'd0, 5'd9}, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
    checkOutput("we0_sel", 32'(obsSel), 32'd0);

    // Flush overrides the stall and kills the consumer's own rd.
    applyStimulus(1'b1, '0, 2'b00, 5'd12, 1'b1, 2'd1, 1'b0);
    applyStimulus(1'b1, {5'd0, 5'd12}, 2'b01, 5'd13, 1'b1, 2'd0, 1'b1);
    checkOutput("flush_stall", 32'(obsStall), 32'd0);
    applyStimulus(1'b1, {5'd12, 5'd13}, 2'b11, 5'd0, 1'b0, 2'd0, 1'b0);
    checkOutput("flush_sel", 32'(obsSel), 32'd8);
    checkOutput("flush_stall_next", 32'(obsStall), 32'd0);
    checkOutput("flush_cnt", 32'(obsCnt), 32'd1);

    // Latency-2 producer: two stall cycles, then forward from entry 2.
    applyStimulus(1'b1, '0, 2'b00, 5'd20, 1'b1, 2'd2, 1'b0);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, {5'd0, 5'd20}, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
      checkOutput("mc_stall", 32'(obsStall), (j < 2) ? 32'd1 : 32'd0);
    end
    checkOutput("mc_sel", 32'(obsSel[SELW-1:0]), 32'd3);

    for (int n = 0; n < 8; n++) begin
      applyStimulus(1'b1, '0, 2'b00, 5'd21, 1'b1, 2'd2, 1'b0);
      repeat (3) applyStimulus(1'b1, {5'd0, 5'd21}, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
    end
    checkOutput("sat_small_cnt", 32'(ifSmall.stall_cnt), 32'd15);
    checkOutput("main_cnt_19", 32'(ifMain.stall_cnt), 32'd19);

    // Asynchronous reset in the middle of a cycle with a live forward.
    applyStimulus(1'b1, '0, 2'b00, 5'd4, 1'b1, 2'd0, 1'b0);
    ifMain.id_rs      = {5'd0, 5'd4};
    ifMain.id_rs_used = 2'b01;
    ifMain.id_we      = 1'b0;
    #2;
    checkOutput("prereset_sel", 32'(ifMain.fwd_sel), 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(posedge clk);
    #1;
    checkResetOutputs("midreset_hold");
    releaseReset();

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NSRC; i++) r[i*RAW +: RAW] = RAW'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 3) != 0), r, NSRC'($urandom), RAW'($urandom_range(0, 7)),
                    1'($urandom), LATW'($urandom_range(0, DEPTH-1)), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
